// File: rtl/expr_eval_if.sv
// Character-stream handshake between a driver and the expr_eval evaluator.
// The driver presents one ASCII character with a valid strobe and reads back the expression status.
interface expr_eval_if #(
   parameter int DATA_W = 16
);
   logic [7:0]               in;
   logic                     in_valid;
   logic                     out;
   logic signed [DATA_W-1:0] result;
   logic                     err;
   logic                     ovf;

   modport master (
      output in, in_valid,
      input  out, result, err, ovf
   );

   modport slave (
      input  in, in_valid,
      output out, result, err, ovf
   );
endinterface

// File: rtl/expr_eval.sv
// Streaming evaluator for "digit (op digit)*" with '*' binding tighter than '+'/'-'.
// Optional macro EXPR_SUB_EN enables '-' as an operator; undefined, '-' is a syntax error.
module expr_eval #(
   parameter int DATA_W      = 16,
   parameter int MULTI_DIGIT = 0
) (
   input  logic        clk,
   input  logic        clr,
   expr_eval_if.slave  bus
);

   localparam int W2 = 2 * DATA_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_NUM  = 2'd1;
   localparam logic [1:0] S_OP   = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   localparam logic signed [W2-1:0]     TEN = W2'(10);
   localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1);

`ifdef EXPR_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   // True when the wide value survives truncation to signed DATA_W unchanged.
   function automatic logic fits(input logic signed [W2-1:0] v);
      logic signed [DATA_W-1:0] t;
      t = v[DATA_W-1:0];
      return (W2'(t) == v);
   endfunction

   function automatic logic signed [DATA_W-1:0] wrap(input logic signed [W2-1:0] v);
      return v[DATA_W-1:0];
   endfunction

   logic [1:0]               state, state_n;
   logic signed [DATA_W-1:0] sum, sum_n;
   logic signed [DATA_W-1:0] prod, prod_n;
   logic signed [DATA_W-1:0] cur, cur_n;
   logic signed [DATA_W-1:0] res, res_n;
   logic                     ovf_q, ovf_n;
   logic                     out_q, err_q;
   logic                     neg;

   logic                     is_digit, is_mul, is_add, is_sub;
   logic                     take_digit, take_mul, take_add, go_err;
   logic signed [W2-1:0]     dig_ext, cur_full, cur_x, term, acc;

`ifdef EXPR_SUB_EN
   logic neg_n;
`else
   assign neg = 1'b0;
`endif

   always_comb begin
      is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
      is_mul   = (bus.in == 8'h2A);
      is_add   = (bus.in == 8'h2B);
      is_sub   = (bus.in == 8'h2D);

      // A digit following a digit extends the operand only in multi-digit mode.
      dig_ext  = W2'(bus.in[3:0]);
      cur_full = ((MULTI_DIGIT != 0) && (state == S_NUM)) ? (W2'(cur) * TEN + dig_ext) : dig_ext;
      cur_x    = is_digit ? cur_full : W2'(cur);
      term     = W2'(prod) * cur_x;
      acc      = W2'(sum) + (neg ? -term : term);

      take_digit = 1'b0;
      take_mul   = 1'b0;
      take_add   = 1'b0;
      go_err     = 1'b0;
      if (bus.in_valid) begin
         case (state)
            S_IDLE: begin
               if (is_digit) take_digit = 1'b1;
               else          go_err     = 1'b1;
            end
            S_NUM: begin
               if (is_digit && (MULTI_DIGIT != 0))  take_digit = 1'b1;
               else if (is_mul)                     take_mul   = 1'b1;
               else if (is_add || (is_sub && SUB_EN)) take_add = 1'b1;
               else                                 go_err     = 1'b1;
            end
            S_OP: begin
               if (is_digit) take_digit = 1'b1;
               else          go_err     = 1'b1;
            end
            default: ;
         endcase
      end

      state_n = state;
      sum_n   = sum;
      prod_n  = prod;
      cur_n   = cur;
      res_n   = res;
      ovf_n   = ovf_q;
`ifdef EXPR_SUB_EN
      neg_n   = neg;
`endif

      if (take_digit) begin
         state_n = S_NUM;
         cur_n   = wrap(cur_full);
         res_n   = wrap(acc);
         ovf_n   = ovf_q | ~fits(cur_full) | ~fits(acc);
      end
      if (take_mul) begin
         state_n = S_OP;
         prod_n  = wrap(term);
         ovf_n   = ovf_q | ~fits(term);
      end
      // Closing a term folds it into sum; the next term starts with a fresh product.
      if (take_add) begin
         state_n = S_OP;
         sum_n   = wrap(acc);
         prod_n  = ONE;
         ovf_n   = ovf_q | ~fits(acc);
`ifdef EXPR_SUB_EN
         neg_n   = is_sub;
`endif
      end
      if (go_err) begin
         state_n = S_ERR;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= S_IDLE;
         sum   <= '0;
         prod  <= ONE;
         cur   <= '0;
         res   <= '0;
         ovf_q <= 1'b0;
         out_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         sum   <= sum_n;
         prod  <= prod_n;
         cur   <= cur_n;
         res   <= res_n;
         ovf_q <= ovf_n;
         out_q <= (state_n == S_NUM);
         err_q <= (state_n == S_ERR);
      end
   end

`ifdef EXPR_SUB_EN
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) neg <= 1'b0;
      else      neg <= neg_n;
   end
`endif

   assign bus.out    = out_q;
   assign bus.err    = err_q;
   assign bus.ovf    = ovf_q;
   assign bus.result = res;

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: three instances (16-bit single-digit, 16-bit multi-digit,
// 8-bit single-digit) share one character stream and reset.
module tb_expr_eval;
   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] ch  = 8'h00;
   logic       vld = 1'b0;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   expr_eval_if #(.DATA_W(16)) if0 ();
   expr_eval_if #(.DATA_W(16)) if1 ();
   expr_eval_if #(.DATA_W(8))  if2 ();

   assign if0.in = ch;  assign if0.in_valid = vld;
   assign if1.in = ch;  assign if1.in_valid = vld;
   assign if2.in = ch;  assign if2.in_valid = vld;

   expr_eval #(.DATA_W(16), .MULTI_DIGIT(0)) u0 (.clk(clk), .clr(clr), .bus(if0));
   expr_eval #(.DATA_W(16), .MULTI_DIGIT(1)) u1 (.clk(clk), .clr(clr), .bus(if1));
   expr_eval #(.DATA_W(8),  .MULTI_DIGIT(0)) u2 (.clk(clk), .clr(clr), .bus(if2));

   task automatic send(input logic [7:0] c);
      @(negedge clk);
      ch  = c;
      vld = 1'b1;
      @(posedge clk);
      #1;
      vld = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      clr = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (if0.out !== 1'b0) begin errors++; $display("FAIL rst_out got %0h want 0", if0.out); end
      checks++; if (if0.err !== 1'b0) begin errors++; $display("FAIL rst_err got %0h want 0", if0.err); end
      checks++; if (if0.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0h want 0", if0.ovf); end
      checks++; if (if0.result !== 16'h0000) begin errors++; $display("FAIL rst_result got %0h want 0", if0.result); end
      @(negedge clk);
      clr = 1'b1;
   endtask

   task automatic test_precedence();
      send("1");
      checks++; if (if0.out !== 1'b1) begin errors++; $display("FAIL prec_out1 got %0h want 1", if0.out); end
      checks++; if (if0.result !== 16'd1) begin errors++; $display("FAIL prec_res1 got %0h want 1", if0.result); end
      send("+");
      checks++; if (if0.out !== 1'b0) begin errors++; $display("FAIL prec_out_op got %0h want 0", if0.out); end
      checks++; if (if0.result !== 16'd1) begin errors++; $display("FAIL prec_res_op got %0h want 1", if0.result); end
      send_str("2*3+4");
      checks++; if (if0.out !== 1'b1) begin errors++; $display("FAIL prec_out got %0h want 1", if0.out); end
      checks++; if (if0.result !== 16'h000B) begin errors++; $display("FAIL prec_result got %0h want b", if0.result); end
      checks++; if (if0.err !== 1'b0) begin errors++; $display("FAIL prec_err got %0h want 0", if0.err); end
      checks++; if (if1.result !== 16'h000B) begin errors++; $display("FAIL prec_md_result got %0h want b", if1.result); end
   endtask

   task automatic test_clr_restart();
      do_clr();
      send_str("1+2+3");
      checks++; if (if0.out !== 1'b1) begin errors++; $display("FAIL restart_out got %0h want 1", if0.out); end
      checks++; if (if0.result !== 16'd6) begin errors++; $display("FAIL restart_result got %0h want 6", if0.result); end
   endtask

   task automatic test_clr_mid();
      do_clr();
      send_str("7*");
      checks++; if (if0.result !== 16'd7) begin errors++; $display("FAIL mid_pre_result got %0h want 7", if0.result); end
      @(negedge clk);
      clr = 1'b0;
      #1;
      checks++; if (if0.result !== 16'd0) begin errors++; $display("FAIL mid_clr_result got %0h want 0", if0.result); end
      checks++; if (if0.out !== 1'b0) begin errors++; $display("FAIL mid_clr_out got %0h want 0", if0.out); end
      @(negedge clk);
      clr = 1'b1;
      send("5");
      checks++; if (if0.result !== 16'd5) begin errors++; $display("FAIL mid_new_result got %0h want 5", if0.result); end
      checks++; if (if0.out !== 1'b1) begin errors++; $display("FAIL mid_new_out got %0h want 1", if0.out); end
   endtask

   task automatic test_syntax_err();
      do_clr();
      send_str("2**");
      checks++; if (if0.err !== 1'b1) begin errors++; $display("FAIL dbl_op_err got %0h want 1", if0.err); end
      checks++; if (if0.out !== 1'b0) begin errors++; $display("FAIL dbl_op_out got %0h want 0", if0.out); end
      send("3");
      checks++; if (if0.err !== 1'b1) begin errors++; $display("FAIL err_hold_err got %0h want 1", if0.err); end
      checks++; if (if0.out !== 1'b0) begin errors++; $display("FAIL err_hold_out got %0h want 0", if0.out); end
      checks++; if (if0.result !== 16'd2) begin errors++; $display("FAIL err_hold_result got %0h want 2", if0.result); end
      do_clr();
      send("+");
      checks++; if (if0.err !== 1'b1) begin errors++; $display("FAIL lead_op_err got %0h want 1", if0.err); end
      do_clr();
      send_str("5a");
      checks++; if (if0.err !== 1'b1) begin errors++; $display("FAIL bad_char_err got %0h want 1", if0.err); end
   endtask

   task automatic test_sub();
      do_clr();
`ifdef EXPR_SUB_EN
      send_str("9-2*3");
      checks++; if (if0.result !== 16'd3) begin errors++; $display("FAIL sub_result got %0h want 3", if0.result); end
      checks++; if (if0.err !== 1'b0) begin errors++; $display("FAIL sub_err got %0h want 0", if0.err); end
`else
      send_str("9-");
      checks++; if (if0.err !== 1'b1) begin errors++; $display("FAIL minus_err got %0h want 1", if0.err); end
      send("2");
      checks++; if (if0.result !== 16'd9) begin errors++; $display("FAIL minus_hold got %0h want 9", if0.result); end
`endif
   endtask

   task automatic test_multi_digit();
      do_clr();
      send_str("12");
      checks++; if (if0.err !== 1'b1) begin errors++; $display("FAIL single_12_err got %0h want 1", if0.err); end
      send_str("*12");
      checks++; if (if1.result !== 16'd144) begin errors++; $display("FAIL md_result got %0d want 144", if1.result); end
      checks++; if (if1.out !== 1'b1) begin errors++; $display("FAIL md_out got %0h want 1", if1.out); end
   endtask

   task automatic test_overflow();
      do_clr();
      send_str("9*9");
      checks++; if (if2.result !== 8'd81) begin errors++; $display("FAIL ovf_pre_result got %0d want 81", if2.result); end
      checks++; if (if2.ovf !== 1'b0) begin errors++; $display("FAIL ovf_pre got %0h want 0", if2.ovf); end
      send_str("*9");
      checks++; if (if2.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %0h want 1", if2.ovf); end
      checks++; if (if2.result !== 8'hD9) begin errors++; $display("FAIL ovf_wrap got %0h want d9", if2.result); end
      checks++; if (if0.result !== 16'd729) begin errors++; $display("FAIL wide_result got %0d want 729", if0.result); end
      checks++; if (if0.ovf !== 1'b0) begin errors++; $display("FAIL wide_ovf got %0h want 0", if0.ovf); end
      send_str("+1");
      checks++; if (if2.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0h want 1", if2.ovf); end
      checks++; if (if2.out !== 1'b1) begin errors++; $display("FAIL ovf_out got %0h want 1", if2.out); end
      do_clr();
      checks++; if (if2.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0h want 0", if2.ovf); end
   endtask

   task automatic test_valid_gap();
      do_clr();
      send_str("3*4");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ch = "+";
         @(posedge clk);
         #1;
         checks++; if (if0.result !== 16'd12) begin errors++; $display("FAIL gap_result%0d got %0d want 12", i, if0.result); end
         checks++; if (if0.out !== 1'b1) begin errors++; $display("FAIL gap_out%0d got %0h want 1", i, if0.out); end
         checks++; if (if0.err !== 1'b0) begin errors++; $display("FAIL gap_err%0d got %0h want 0", i, if0.err); end
      end
      send_str("+5");
      checks++; if (if0.result !== 16'd17) begin errors++; $display("FAIL gap_resume got %0d want 17", if0.result); end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      test_reset();
      test_precedence();
      test_clr_restart();
      test_clr_mid();
      test_syntax_err();
      test_sub();
      test_multi_digit();
      test_overflow();
      test_valid_gap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
